match_controller: RTL and testbench
===================================

# match_controller

Round/match sequencer for the fighting game. Sits between the frame-tick generator and the per-player `fsm`/`health_logic` instances. Issues the round reset, gates character control with `play_en`, runs the countdown, round and result timers, scores round wins and declares the match winner from the `game_over1`/`game_over2` and `health1`/`health2` signals.

## Interface
- `COUNTDOWN_FRAMES`, 180: pre-fight frames; must be ≥1.
- `ROUND_FRAMES`, 5400: fight time limit in frames; must be ≥1 and < 2^TW.
- `ROUND_OVER_FRAMES`, 120: result-display frames; must be ≥1.
- `WINS_NEEDED`, 2: round wins that end the match; range 1–3.
- `MAX_ROUNDS`, 5: hard round limit; range 1–7.
- `TW`, 13: timer width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `tick` in 1: one-`clk` frame enable.
- `start` in 1: level input; rising edge detected internally.
- `game_over1` in 1: player 1 health is zero.
- `game_over2` in 1: player 2 health is zero.
- `health1` in 2: player 1 health, used for the timeout decision.
- `health2` in 2: player 2 health, used for the timeout decision.
- `state` out 3: current state encoding.
- `play_en` out 1: characters may move or attack.
- `round_reset` out 1: one-cycle reset to `fsm`/`health_logic`.
- `frames_left` out TW: active timer value.
- `wins1` out 2: player 1 round wins.
- `wins2` out 2: player 2 round wins.
- `round_num` out 3: current round number, 1-based; 0 in IDLE.
- `round_winner` out 2: result of the last round. 00 = none, 01 = P1, 10 = P2, 11 = draw.
- `match_winner` out 2: same encoding; valid in MATCH_OVER only, 00 otherwise.

## Operation
- States: IDLE=0, ROUND_INIT=1, COUNTDOWN=2, FIGHT=3, ROUND_OVER=4, MATCH_OVER=5. Codes 6/7 go to IDLE on the next clock.
- `start_rise` = `start` & ~`start_q`, where `start_q` is a register. It is evaluated every clock, independent of `tick`.
- IDLE: on `start_rise` → ROUND_INIT. Clear wins, `round_num`←0, `round_winner`←00.
- ROUND_INIT (one cycle):
  - `round_reset`=1.
  - `round_num`+=1.
  - `frames_left`←COUNTDOWN_FRAMES.
  - Next state COUNTDOWN.
- COUNTDOWN: on `tick`, if `frames_left`==1 → FIGHT with `frames_left`←ROUND_FRAMES; otherwise decrement.
- FIGHT: `play_en`=1. Round end is checked every clock, in priority order:
  1. `game_over1` & `game_over2` → draw.
  2. `game_over1` → P2 wins.
  3. `game_over2` → P1 wins.
  4. `tick` & `frames_left`==1 → timeout: higher health wins; equal health is a draw.
  5. Otherwise, on `tick`, decrement.
- Any round end:
  - Go to ROUND_OVER and set `round_winner`.
  - Increment the winner's win count, saturating at 3.
  - `frames_left`←ROUND_OVER_FRAMES.
- ROUND_OVER: on `tick`, decrement. At `frames_left`==1 & `tick`:
  - If `wins1`==WINS_NEEDED or `wins2`==WINS_NEEDED, or `round_num`==MAX_ROUNDS → MATCH_OVER.
  - Otherwise → ROUND_INIT.
- MATCH_OVER:
  - `match_winner`: P1 if `wins1`>`wins2`, P2 if `wins2`>`wins1`, draw (11) if equal.
  - `frames_left`=0.
  - `start_rise` → ROUND_INIT with wins, `round_num` and `round_winner` cleared.
- `play_en`=0 in every state except FIGHT.
- `start` is ignored outside IDLE and MATCH_OVER.
- `frames_left`=0 in IDLE.

## Timing
- All outputs are registered (Moore, decoded from registered state/counters). No combinational path from inputs to outputs.
- Reset values: `state`=0, `play_en`=0, `round_reset`=0, `frames_left`=0, `wins1`=`wins2`=0, `round_num`=0, `round_winner`=00, `match_winner`=00, `start_q`=0.
- `start_rise` at edge N → `state`=1 and `round_reset`=1 during cycle N+1 → `state`=2 at N+2.
- `game_over` high at edge N in FIGHT → `state`=4 and `play_en`=0 from N+1. The win count is updated at the same edge.
- COUNTDOWN lasts exactly COUNTDOWN_FRAMES ticks; FIGHT lasts ≤ ROUND_FRAMES ticks.
- `tick` high on the same cycle as a `game_over` in FIGHT: `game_over` wins; there is no decrement.
- `game_over` inputs are ignored outside FIGHT, including stale values during ROUND_INIT and COUNTDOWN.
- Asserting `reset` mid-round returns to IDLE immediately, with all outputs at their reset values.

## Test plan
Bench parameters: COUNTDOWN_FRAMES=3, ROUND_FRAMES=10, ROUND_OVER_FRAMES=2, WINS_NEEDED=2, MAX_ROUNDS=3. `tick` every 4 clocks.

- **Reset and start:** reset, then `start` 0→1 → `round_reset` pulses exactly 1 cycle, `round_num`=1. `state` goes 1→2, and reaches 3 after the 3rd tick with `frames_left`=10.
- **KO:** `game_over2`=1 in FIGHT → next cycle `state`=4, `round_winner`=01, `wins1`=1, `play_en`=0. After 2 ticks → `state`=1 and `round_num`=2.
- **Timeout:** no KO, `health1`=1, `health2`=3 → after 10 ticks `round_winner`=10, `wins2`=1. With equal health → `round_winner`=11 and wins unchanged.
- **Double KO with tick:** `game_over1`=`game_over2`=1 on the same cycle as `tick` → draw, `frames_left` not decremented.
- **Match end:** P1 wins 2 rounds → `state`=5, `match_winner`=01. Holding `start` high does nothing; a new rising edge restarts with wins=0 and `round_num`=1.
- **Round limit and reset:** three draws → `state`=5, `match_winner`=11 after round 3. Asserting `reset` mid-FIGHT → `state`=0, all outputs zero within the same cycle.

Source files
------------

// File: rtl/match_controller.sv
// -----------------------------------------------------------------------------
// match_controller
//
// Round/match sequencer for the fighting game. Sits between the frame-tick
// generator and the per-player fsm/health_logic instances. It issues the
// one-cycle round reset, gates character control with play_en, and runs the
// countdown, fight and result timers. It also scores round wins and declares
// the match winner from the game_over and health inputs.
//
// Parameters
//   COUNTDOWN_FRAMES  : pre-fight frames (>= 1)
//   ROUND_FRAMES      : fight time limit in frames (>= 1, < 2**TW)
//   ROUND_OVER_FRAMES : result-display frames (>= 1)
//   WINS_NEEDED       : round wins that end the match (1..3)
//   MAX_ROUNDS        : hard round limit (1..7)
//   TW                : timer width
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   tick         in   one-clk frame enable
//   start        in   level input; its rising edge is detected internally
//   game_over1   in   player 1 health is zero
//   game_over2   in   player 2 health is zero
//   health1      in   [1:0] player 1 health, used for the timeout decision
//   health2      in   [1:0] player 2 health, used for the timeout decision
//   state        out  [2:0] current state encoding
//   play_en      out  characters may move or attack (FIGHT only)
//   round_reset  out  one-cycle reset pulse to fsm/health_logic
//   frames_left  out  [TW-1:0] active timer value
//   wins1        out  [1:0] player 1 round wins
//   wins2        out  [1:0] player 2 round wins
//   round_num    out  [2:0] current round, 1-based; 0 in IDLE
//   round_winner out  [1:0] last round result: 00 none, 01 P1, 10 P2, 11 draw
//   match_winner out  [1:0] same encoding; non-zero in MATCH_OVER only
//
// All outputs come straight from registers, so there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module match_controller #(
  parameter int COUNTDOWN_FRAMES  = 180,
  parameter int ROUND_FRAMES      = 5400,
  parameter int ROUND_OVER_FRAMES = 120,
  parameter int WINS_NEEDED       = 2,
  parameter int MAX_ROUNDS        = 5,
  parameter int TW                = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          start,
  input  logic          game_over1,
  input  logic          game_over2,
  input  logic [1:0]    health1,
  input  logic [1:0]    health2,
  output logic [2:0]    state,
  output logic          play_en,
  output logic          round_reset,
  output logic [TW-1:0] frames_left,
  output logic [1:0]    wins1,
  output logic [1:0]    wins2,
  output logic [2:0]    round_num,
  output logic [1:0]    round_winner,
  output logic [1:0]    match_winner
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ROUND_INIT = 3'd1,
    S_COUNTDOWN  = 3'd2,
    S_FIGHT      = 3'd3,
    S_ROUND_OVER = 3'd4,
    S_MATCH_OVER = 3'd5
  } state_t;

  // Timer reload values and score limits, cut down to their register widths.
  localparam logic [TW-1:0] CD_LOAD     = COUNTDOWN_FRAMES[TW-1:0];
  localparam logic [TW-1:0] RF_LOAD     = ROUND_FRAMES[TW-1:0];
  localparam logic [TW-1:0] RO_LOAD     = ROUND_OVER_FRAMES[TW-1:0];
  localparam logic [TW-1:0] FL_ONE      = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] FL_ZERO     = '0;
  localparam logic [1:0]    WINS_GOAL   = WINS_NEEDED[1:0];
  localparam logic [2:0]    ROUND_LIMIT = MAX_ROUNDS[2:0];

  // Result encoding shared by round_winner and match_winner.
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic          r_start_q;
  logic          r_play_en;
  logic          r_round_reset;
  logic [TW-1:0] r_frames_left;
  logic [1:0]    r_wins1;
  logic [1:0]    r_wins2;
  logic [2:0]    r_round_num;
  logic [1:0]    r_round_winner;
  logic [1:0]    r_match_winner;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  logic       w_start_rise;
  logic       w_last_frame;
  logic       w_match_done;
  logic [1:0] w_fight_result;
  logic       w_round_end;
  logic [1:0] w_final_winner;
  logic [1:0] w_wins1_inc;
  logic [1:0] w_wins2_inc;

  // Edge detect runs every clock, independent of tick.
  assign w_start_rise = start & ~r_start_q;

  // The current timer value is about to be consumed by this frame.
  assign w_last_frame = tick && (r_frames_left == FL_ONE);

  // Evaluated at the end of the result display, with the final scores.
  assign w_match_done = (r_wins1 == WINS_GOAL) || (r_wins2 == WINS_GOAL) ||
                        (r_round_num == ROUND_LIMIT);

  // Win counters saturate at 3 so a small WINS_NEEDED can never wrap them.
  assign w_wins1_inc = (r_wins1 == 2'd3) ? 2'd3 : r_wins1 + 2'd1;
  assign w_wins2_inc = (r_wins2 == 2'd3) ? 2'd3 : r_wins2 + 2'd1;

  // Fight outcome for this clock; RES_NONE means the round carries on.
  // A knockout outranks the timeout, even when it lands on the final tick.
  always_comb begin
    w_fight_result = RES_NONE;
    if (game_over1 && game_over2) begin
      w_fight_result = RES_DRAW;
    end else if (game_over1) begin
      w_fight_result = RES_P2;
    end else if (game_over2) begin
      w_fight_result = RES_P1;
    end else if (w_last_frame) begin
      if (health1 > health2) begin
        w_fight_result = RES_P1;
      end else if (health2 > health1) begin
        w_fight_result = RES_P2;
      end else begin
        w_fight_result = RES_DRAW;
      end
    end
  end

  assign w_round_end = (w_fight_result != RES_NONE);

  always_comb begin
    w_final_winner = RES_DRAW;
    if (r_wins1 > r_wins2) begin
      w_final_winner = RES_P1;
    end else if (r_wins2 > r_wins1) begin
      w_final_winner = RES_P2;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer. Outputs are loaded on the edge that enters a state, so they
  // are already valid during that state's first cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_start_q      <= 1'b0;
      r_play_en      <= 1'b0;
      r_round_reset  <= 1'b0;
      r_frames_left  <= FL_ZERO;
      r_wins1        <= 2'd0;
      r_wins2        <= 2'd0;
      r_round_num    <= 3'd0;
      r_round_winner <= RES_NONE;
      r_match_winner <= RES_NONE;
    end else begin
      r_start_q     <= start;
      // Pulses: only the transitions below raise them, for one cycle.
      r_play_en     <= 1'b0;
      r_round_reset <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_wins1        <= 2'd0;
          r_wins2        <= 2'd0;
          r_round_winner <= RES_NONE;
          r_match_winner <= RES_NONE;
          r_frames_left  <= FL_ZERO;
          r_round_num    <= 3'd0;
          if (w_start_rise) begin
            // Round counter is 0 here, so the first round becomes 1.
            r_state       <= S_ROUND_INIT;
            r_round_reset <= 1'b1;
            r_round_num   <= 3'd1;
            r_frames_left <= CD_LOAD;
          end
        end

        S_ROUND_INIT: begin
          r_state <= S_COUNTDOWN;
        end

        S_COUNTDOWN: begin
          if (tick) begin
            if (r_frames_left == FL_ONE) begin
              r_state       <= S_FIGHT;
              r_play_en     <= 1'b1;
              r_frames_left <= RF_LOAD;
            end else begin
              r_frames_left <= r_frames_left - FL_ONE;
            end
          end
        end

        S_FIGHT: begin
          if (w_round_end) begin
            r_state        <= S_ROUND_OVER;
            r_round_winner <= w_fight_result;
            r_frames_left  <= RO_LOAD;
            if (w_fight_result == RES_P1) begin
              r_wins1 <= w_wins1_inc;
            end
            if (w_fight_result == RES_P2) begin
              r_wins2 <= w_wins2_inc;
            end
          end else begin
            r_play_en <= 1'b1;
            if (tick) begin
              r_frames_left <= r_frames_left - FL_ONE;
            end
          end
        end

        S_ROUND_OVER: begin
          if (tick) begin
            if (r_frames_left == FL_ONE) begin
              if (w_match_done) begin
                r_state        <= S_MATCH_OVER;
                r_frames_left  <= FL_ZERO;
                r_match_winner <= w_final_winner;
              end else begin
                r_state       <= S_ROUND_INIT;
                r_round_reset <= 1'b1;
                r_round_num   <= r_round_num + 3'd1;
                r_frames_left <= CD_LOAD;
              end
            end else begin
              r_frames_left <= r_frames_left - FL_ONE;
            end
          end
        end

        S_MATCH_OVER: begin
          r_frames_left <= FL_ZERO;
          if (w_start_rise) begin
            // Rematch: scores and result clear, round counting restarts at 1.
            r_state        <= S_ROUND_INIT;
            r_round_reset  <= 1'b1;
            r_round_num    <= 3'd1;
            r_frames_left  <= CD_LOAD;
            r_wins1        <= 2'd0;
            r_wins2        <= 2'd0;
            r_round_winner <= RES_NONE;
            r_match_winner <= RES_NONE;
          end
        end

        default: begin
          // Unused codes 6/7 fall back to a clean IDLE.
          r_state        <= S_IDLE;
          r_frames_left  <= FL_ZERO;
          r_wins1        <= 2'd0;
          r_wins2        <= 2'd0;
          r_round_num    <= 3'd0;
          r_round_winner <= RES_NONE;
          r_match_winner <= RES_NONE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign state        = r_state;
  assign play_en      = r_play_en;
  assign round_reset  = r_round_reset;
  assign frames_left  = r_frames_left;
  assign wins1        = r_wins1;
  assign wins2        = r_wins2;
  assign round_num    = r_round_num;
  assign round_winner = r_round_winner;
  assign match_winner = r_match_winner;

endmodule

// File: tb/tb_match_controller.sv
// -----------------------------------------------------------------------------
// tb_match_controller
//
// Self-checking bench for match_controller. Rounds are played as transactions
// (knockout kinds, timeouts with chosen health, double KO on a tick). The
// expected winners, scores, timer values and match results come from a
// round-level model built from the game rules. A free-running tick is
// generated every 4 clocks.
// -----------------------------------------------------------------------------
module tb_match_controller;

  localparam int CD  = 3;
  localparam int RF  = 10;
  localparam int ROF = 2;
  localparam int WN  = 2;
  localparam int MR  = 3;
  localparam int TW  = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic          game_over1 = 1'b0;
  logic          game_over2 = 1'b0;
  logic [1:0]    health1 = 2'd0;
  logic [1:0]    health2 = 2'd0;
  logic [2:0]    state;
  logic          play_en;
  logic          round_reset;
  logic [TW-1:0] frames_left;
  logic [1:0]    wins1;
  logic [1:0]    wins2;
  logic [2:0]    round_num;
  logic [1:0]    round_winner;
  logic [1:0]    match_winner;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;

  // Round-level model of the score.
  int m_w1;
  int m_w2;
  int m_round;

  match_controller #(
    .COUNTDOWN_FRAMES (CD),
    .ROUND_FRAMES     (RF),
    .ROUND_OVER_FRAMES(ROF),
    .WINS_NEEDED      (WN),
    .MAX_ROUNDS       (MR),
    .TW               (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .game_over1  (game_over1),
    .game_over2  (game_over2),
    .health1     (health1),
    .health2     (health2),
    .state       (state),
    .play_en     (play_en),
    .round_reset (round_reset),
    .frames_left (frames_left),
    .wins1       (wins1),
    .wins2       (wins2),
    .round_num   (round_num),
    .round_winner(round_winner),
    .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  // Frame enable: one clock high out of every four.
  initial begin
    forever begin
      @(negedge clk);
      tick = (tick_cnt == 3);
      tick_cnt = (tick_cnt + 1) % 4;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_play_en"}, 32'(play_en), 0);
    check({tag, "_round_reset"}, 32'(round_reset), 0);
    check({tag, "_frames"}, 32'(frames_left), 0);
    check({tag, "_wins1"}, 32'(wins1), 0);
    check({tag, "_wins2"}, 32'(wins2), 0);
    check({tag, "_round_num"}, 32'(round_num), 0);
    check({tag, "_round_winner"}, 32'(round_winner), 0);
    check({tag, "_match_winner"}, 32'(match_winner), 0);
  endtask

  function automatic int winner_of(input int a, input int b);
    if (a > b) return 1;
    if (b > a) return 2;
    return 3;
  endfunction

  // Create a fresh rising edge on start; expects the DUT idle or match over.
  task automatic start_match();
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    check("init_state", 32'(state), 1);
    check("init_round_reset", 32'(round_reset), 1);
    check("init_play_en", 32'(play_en), 0);
    check("init_wins1", 32'(wins1), 0);
    check("init_wins2", 32'(wins2), 0);
    check("init_round_winner", 32'(round_winner), 0);
    check("init_match_winner", 32'(match_winner), 0);
    m_w1 = 0;
    m_w2 = 0;
    m_round = 1;
  endtask

  // From the ROUND_INIT cycle through the countdown into FIGHT.
  task automatic run_to_fight();
    int cnt;
    int guard;
    logic tk;
    @(posedge clk); #1;
    check("cd_state", 32'(state), 2);
    check("cd_round_reset", 32'(round_reset), 0);
    check("cd_round_num", 32'(round_num), 32'(m_round));
    check("cd_frames_start", 32'(frames_left), CD);
    // Stale game_over values were held through ROUND_INIT; drop them now.
    game_over1 = 1'b0;
    game_over2 = 1'b0;
    cnt = 0;
    guard = 0;
    while (state == 3'd2 && guard < 200) begin
      @(posedge clk);
      tk = tick;
      #1;
      guard++;
      if (tk) cnt++;
      if (state == 3'd2) check("cd_frames", 32'(frames_left), 32'(CD - cnt));
    end
    check("cd_ticks", 32'(cnt), CD);
    check("fight_state", 32'(state), 3);
    check("fight_frames_start", 32'(frames_left), RF);
    check("fight_play_en", 32'(play_en), 1);
  endtask

  // kind: 0 P2 KO'd, 1 P1 KO'd, 2 double KO, 3 timeout, 4 double KO on a tick.
  task automatic play_round(input int kind, input int k, input int h1, input int h2,
                            output bit match_over);
    int ticks_seen;
    int guard;
    int exp_res;
    int cnt;
    bit done;
    bit ko;
    logic tk;

    health1 = h1[1:0];
    health2 = h2[1:0];
    case (kind)
      0:       exp_res = 1;
      1:       exp_res = 2;
      3:       exp_res = winner_of(h1, h2);
      default: exp_res = 3;
    endcase

    ticks_seen = 0;
    done = 1'b0;
    guard = 0;
    while (!done && guard < 300) begin
      @(negedge clk); #1;
      guard++;
      ko = ((kind < 3) && (ticks_seen == k)) || ((kind == 4) && (ticks_seen == k) && tick);
      game_over1 = ko && (kind == 1 || kind == 2 || kind == 4);
      game_over2 = ko && (kind == 0 || kind == 2 || kind == 4);
      // Rising edges of start during a fight must be ignored.
      start = 1'($urandom_range(0, 1));
      tk = tick;
      @(posedge clk); #1;
      if (ko) begin
        done = 1'b1;
      end else if (tk) begin
        ticks_seen++;
        if (ticks_seen == RF) done = 1'b1;
      end
      if (!done) begin
        check("fight_frames", 32'(frames_left), 32'(RF - ticks_seen));
        check("fight_hold", 32'({state, play_en}), 32'({3'd3, 1'b1}));
      end
    end
    start = 1'b1;
    check("round_end_ticks", 32'(ticks_seen), (kind == 3) ? RF : k);

    if (exp_res == 1 && m_w1 < 3) m_w1++;
    if (exp_res == 2 && m_w2 < 3) m_w2++;
    check("ro_state", 32'(state), 4);
    check("ro_play_en", 32'(play_en), 0);
    check("ro_round_winner", 32'(round_winner), 32'(exp_res));
    check("ro_frames", 32'(frames_left), ROF);
    check("ro_wins1", 32'(wins1), 32'(m_w1));
    check("ro_wins2", 32'(wins2), 32'(m_w2));
    $display("round %0d kind=%0d k=%0d health=%0d/%0d winner=%0d wins=%0d-%0d",
             m_round, kind, k, h1, h2, exp_res, m_w1, m_w2);

    cnt = 0;
    guard = 0;
    while (state == 3'd4 && guard < 200) begin
      @(posedge clk);
      tk = tick;
      #1;
      guard++;
      if (tk) cnt++;
      if (state == 3'd4) check("ro_frames_run", 32'(frames_left), 32'(ROF - cnt));
    end
    check("ro_ticks", 32'(cnt), ROF);

    match_over = (m_w1 == WN) || (m_w2 == WN) || (m_round == MR);
    if (match_over) begin
      check("mo_state", 32'(state), 5);
      check("mo_match_winner", 32'(match_winner), 32'(winner_of(m_w1, m_w2)));
      check("mo_frames", 32'(frames_left), 0);
      check("mo_round_num", 32'(round_num), 32'(m_round));
      $display("match over after round %0d winner=%0d", m_round, winner_of(m_w1, m_w2));
    end else begin
      check("next_state", 32'(state), 1);
      check("next_round_reset", 32'(round_reset), 1);
      m_round++;
    end
  endtask

  // A negative kind picks a random round.
  task automatic run_match(input int kinds[3], input int hs1[3], input int hs2[3]);
    bit mo;
    int kind;
    int h1;
    int h2;
    mo = 1'b0;
    start_match();
    for (int r = 0; r < MR && !mo; r++) begin
      run_to_fight();
      kind = kinds[r];
      h1 = hs1[r];
      h2 = hs2[r];
      if (kind < 0) begin
        kind = $urandom_range(0, 4);
        h1 = $urandom_range(0, 3);
        h2 = $urandom_range(0, 3);
      end
      play_round(kind, $urandom_range(0, RF - 1), h1, h2, mo);
    end
    // Holding start high in MATCH_OVER is not a new rising edge.
    repeat (6) @(posedge clk);
    #1;
    check("mo_hold_state", 32'(state), 5);
    check("mo_hold_winner", 32'(match_winner), 32'(winner_of(m_w1, m_w2)));
  endtask

  initial begin
    bit mo;
    int ka[3];
    int ha1[3];
    int ha2[3];

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("idle");

    // P1 wins two KO rounds.
    ka = '{0, 0, 0};   ha1 = '{3, 3, 3}; ha2 = '{0, 0, 0};
    run_match(ka, ha1, ha2);
    // Timeout P2 win, equal-health timeout draw, double KO on a tick.
    ka = '{3, 3, 4};   ha1 = '{1, 2, 0}; ha2 = '{3, 2, 0};
    run_match(ka, ha1, ha2);
    // Three draws hit the round limit.
    ka = '{2, 4, 3};   ha1 = '{0, 0, 3}; ha2 = '{0, 0, 3};
    run_match(ka, ha1, ha2);
    // Random matches.
    ka = '{-1, -1, -1}; ha1 = '{0, 0, 0}; ha2 = '{0, 0, 0};
    repeat (5) run_match(ka, ha1, ha2);

    // Reset asserted mid-FIGHT, with a non-zero score on the board.
    start_match();
    run_to_fight();
    play_round(0, 2, 0, 0, mo);
    run_to_fight();
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    start = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset_hold");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_state", 32'(state), 0);
    check("post_reset_frames", 32'(frames_left), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
